rv_run_ctrl: RTL
================

# rv_run_ctrl

Run controller for the single-cycle RISC-V core. It loads the instruction memory from a host command port, sequences core reset, and gates execution through a core enable. Execution modes are free-run, host halt, single-step and automatic halt on `ebreak`. It sits between the host/test harness and the core wrapper: it drives the wrapper's active-low reset and a PC/register-write enable.

## Interface
Parameters:
- `IMEM_AW`, default 8: instruction-memory word-address width.
- `EBREAK_INSN`, default 32'h0010_0073: instruction encoding that triggers a halt.
- `MAX_CYCLES`, default 1024: watchdog limit, used only with the macro in Configuration.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `host_cmd_valid` in 1: a command is presented.
- `host_cmd_ready` out 1: controller can accept a command.
- `host_cmd` in 3: command code. 0 NOP, 1 LOAD, 2 START, 3 HALT, 4 STEP, 5 RESUME, 6 ABORT, 7 reserved.
- `host_addr` in IMEM_AW: LOAD word address.
- `host_wdata` in 32: LOAD data.
- `cmd_err` out 1: one-cycle pulse when an accepted command is illegal in the current state.
- `imem_we` out 1: instruction-memory write strobe.
- `imem_waddr` out IMEM_AW: instruction-memory write address.
- `imem_wdata` out 32: instruction-memory write data.
- `core_rst_n` out 1: drives the core wrapper reset (active-low).
- `core_en` out 1: PC-update and RegWrite/MemWrite qualifier.
- `core_instr` in 32: current instruction fetched by the core.
- `state` out 3: FSM state. 0 IDLE, 1 RST_PULSE, 2 RUN, 3 STEP, 4 HALT.
- `halt_cause` out 2: 0 NONE, 1 HOST, 2 EBREAK, 3 TIMEOUT.
- `cycle_cnt` out 32: number of enabled (committed) core cycles.

## Operation
- A command is accepted on an edge where `host_cmd_valid` and `host_cmd_ready` are both 1. `host_cmd_ready` = 0 in RST_PULSE and STEP, otherwise 1.
- IDLE: `core_rst_n`=0, `core_en`=0.
  - LOAD is legal.
  - START moves to RST_PULSE.
  - HALT, STEP and RESUME are illegal.
- RST_PULSE: `core_rst_n`=0 for exactly one cycle, `cycle_cnt` is cleared and `halt_cause` is set to NONE. Next state is RUN.
- RUN: `core_rst_n`=1.
  - `core_en` is combinational: 1 unless `core_instr`==EBREAK_INSN or the watchdog has hit. The `ebreak` instruction is therefore never committed and the PC stays on it.
  - EBREAK seen: go to HALT with cause EBREAK.
  - HALT command: go to HALT with cause HOST. The cycle in which the command is accepted still commits.
  - LOAD, STEP and RESUME are illegal.
- HALT: `core_rst_n`=1, `core_en`=0; register, memory and PC state are preserved.
  - LOAD is legal.
  - START restarts through RST_PULSE.
  - STEP goes to STEP.
  - RESUME goes to RUN and sets cause NONE.
  - If cause is EBREAK or TIMEOUT, STEP and RESUME are accepted with no effect and no `cmd_err`; the state stays HALT.
- STEP: `core_en`=1 for exactly one cycle, then back to HALT with cause HOST. If `core_instr`==EBREAK_INSN, `core_en`=0 and the cause becomes EBREAK.
- ABORT is legal in IDLE, RUN and HALT. It goes to IDLE with cause NONE and leaves `cycle_cnt` unchanged.
- NOP is always legal and does nothing.
- Illegal commands are consumed: no state change, `cmd_err` pulses the next cycle.
- `cycle_cnt` increments on every edge where `core_en`=1 and saturates at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - `state`=IDLE, `halt_cause`=NONE, `cycle_cnt`=0
  - `core_rst_n`=0, `core_en`=0
  - `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0
  - `cmd_err`=0, `host_cmd_ready`=1
- State changes on the accept edge.
- LOAD: `imem_we`, `imem_waddr` and `imem_wdata` are registered and asserted for one cycle, the cycle after accept. Back-to-back LOADs give one write per cycle.
- START from IDLE: RST_PULSE one cycle, then RUN. The first committed instruction is at PC 0, two cycles after the accept edge.
- EBREAK halt: HALT is entered on the edge after `core_instr` matches; `core_en` is 0 in the matching cycle.
- `rst` asserted mid-operation: all outputs return to their reset values immediately (asynchronous). A pending imem write is dropped.

## Configuration
- `RV_RUN_CTRL_WATCHDOG_EN` defined:
  - In RUN, when `cycle_cnt`==MAX_CYCLES, `core_en` is forced to 0 and HALT is entered on the next edge with cause TIMEOUT.
  - STEP ignores the watchdog.
- Undefined: no watchdog logic is present; cause 3 never occurs and MAX_CYCLES is unused.

## Structure
- `rv_run_ctrl_pkg` holds:
  - command codes
  - state encoding
  - halt-cause encoding
  - EBREAK_INSN default constant
- One sub-module: `run_cycle_counter`, a 32-bit counter with synchronous clear, enable and saturation, on the same asynchronous active-low reset.

## Test plan
- Reset, then LOAD 0x00100073 to address 3, then START:
  - `imem_we` pulses with addr 3 and data 0x00100073;
  - `core_rst_n` is low one cycle, then high;
  - the core runs 3 cycles, then halts with `halt_cause`=2, `cycle_cnt`=3, PC 12.
- Free-run no-`ebreak` program, HALT accepted in the 5th RUN cycle → `cycle_cnt`=5, `halt_cause`=1. Then STEP twice → `cycle_cnt`=7 and `state` returns to HALT each time.
- STEP while parked on `ebreak` → `cycle_cnt` unchanged, state HALT, no `cmd_err`. Then START → RST_PULSE, `cycle_cnt`=0, run resumes from PC 0.
- Illegal commands: STEP in IDLE and LOAD in RUN → each gives a one-cycle `cmd_err`, no `imem_we`, state unchanged.
- `rst` deasserted... i.e. asserted low mid-RUN at `cycle_cnt`=10 → outputs return to reset values immediately; after release, `state`=IDLE and `cycle_cnt`=0.
- With `RV_RUN_CTRL_WATCHDOG_EN` and MAX_CYCLES=16, run an infinite loop → HALT with `halt_cause`=3 and `cycle_cnt`=16. A following RESUME has no effect.

Source files
------------

// File: rtl/rv_run_ctrl_pkg.sv
// Shared encodings for the RISC-V run controller: host commands, FSM states,
// halt causes, the default ebreak encoding and the command-legality table.
package rv_run_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_NOP    = 3'd0,
        CMD_LOAD   = 3'd1,
        CMD_START  = 3'd2,
        CMD_HALT   = 3'd3,
        CMD_STEP   = 3'd4,
        CMD_RESUME = 3'd5,
        CMD_ABORT  = 3'd6,
        CMD_RSVD   = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RST_PULSE = 3'd1,
        ST_RUN       = 3'd2,
        ST_STEP      = 3'd3,
        ST_HALT      = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_HOST    = 2'd1,
        CAUSE_EBREAK  = 2'd2,
        CAUSE_TIMEOUT = 2'd3
    } cause_e;

    localparam logic [31:0] EBREAK_INSN_DEFAULT = 32'h0010_0073;

    // Which commands a given state will act on; anything else raises cmd_err.
    function automatic logic cmd_legal(input state_e st, input cmd_e cmd);
        logic ok;
        ok = 1'b0;
        unique case (st)
            ST_IDLE: ok = cmd inside {CMD_NOP, CMD_LOAD, CMD_START, CMD_ABORT};
            ST_RUN:  ok = cmd inside {CMD_NOP, CMD_HALT, CMD_ABORT};
            ST_HALT: ok = cmd inside {CMD_NOP, CMD_LOAD, CMD_START, CMD_STEP,
                                      CMD_RESUME, CMD_ABORT};
            default: ok = (cmd == CMD_NOP);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// 32-bit committed-cycle counter: synchronous clear, count enable, saturates
// at all-ones.
module run_cycle_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] count
);

    // NOTE: state registers use non-blocking assignments inside a single
    // always_ff with the asynchronous active-low reset in its sensitivity list.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/rv_run_ctrl.sv
// Run controller for the single-cycle RISC-V core: imem loading, core reset
// sequencing and execution gating. Define RV_RUN_CTRL_WATCHDOG_EN for the timeout.
module rv_run_ctrl
    import rv_run_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_AW     = 8,
    parameter logic [31:0] EBREAK_INSN = EBREAK_INSN_DEFAULT,
    parameter int unsigned MAX_CYCLES  = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               host_cmd_valid,
    output logic               host_cmd_ready,
    input  logic [2:0]         host_cmd,
    input  logic [IMEM_AW-1:0] host_addr,
    input  logic [31:0]        host_wdata,
    output logic               cmd_err,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_waddr,
    output logic [31:0]        imem_wdata,
    output logic               core_rst_n,
    output logic               core_en,
    input  logic [31:0]        core_instr,
    output logic [2:0]         state,
    output logic [1:0]         halt_cause,
    output logic [31:0]        cycle_cnt
);

    state_e st;
    cause_e cause;
    cmd_e   cmd;
    logic   accept;
    logic   do_cmd;
    logic   is_ebreak;
    logic   wd_hit;

    assign cmd       = cmd_e'(host_cmd);
    assign accept    = host_cmd_valid && host_cmd_ready;
    assign do_cmd    = accept && cmd_legal(st, cmd);
    assign is_ebreak = (core_instr == EBREAK_INSN);

`ifdef RV_RUN_CTRL_WATCHDOG_EN
    assign wd_hit = (st == ST_RUN) && (cycle_cnt == 32'(MAX_CYCLES));
`else
    assign wd_hit = 1'b0;
`endif

    assign host_cmd_ready = !(st inside {ST_RST_PULSE, ST_STEP});
    assign core_rst_n     = !(st inside {ST_IDLE, ST_RST_PULSE});
    assign state          = st;
    assign halt_cause     = cause;

    // core_en must be combinational so an ebreak is blocked in the very cycle
    // it is fetched, leaving the PC parked on it.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        core_en = 1'b0;
        unique case (st)
            ST_RUN:  core_en = !is_ebreak && !wd_hit;
            ST_STEP: core_en = !is_ebreak;
            default: core_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= ST_IDLE;
            cause      <= CAUSE_NONE;
            cmd_err    <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            cmd_err <= accept && !cmd_legal(st, cmd);
            imem_we <= do_cmd && (cmd == CMD_LOAD);
            if (do_cmd && (cmd == CMD_LOAD)) begin
                imem_waddr <= host_addr;
                imem_wdata <= host_wdata;
            end

            unique case (st)
                ST_IDLE: begin
                    if (do_cmd && (cmd == CMD_START)) begin
                        st    <= ST_RST_PULSE;
                        cause <= CAUSE_NONE;
                    end
                end
                ST_RST_PULSE: st <= ST_RUN;
                ST_RUN: begin
                    // ABORT wins; automatic halts outrank a host HALT.
                    if (do_cmd && (cmd == CMD_ABORT)) begin
                        st    <= ST_IDLE;
                        cause <= CAUSE_NONE;
                    end else if (is_ebreak) begin
                        st    <= ST_HALT;
                        cause <= CAUSE_EBREAK;
                    end else if (wd_hit) begin
                        st    <= ST_HALT;
                        cause <= CAUSE_TIMEOUT;
                    end else if (do_cmd && (cmd == CMD_HALT)) begin
                        st    <= ST_HALT;
                        cause <= CAUSE_HOST;
                    end
                end
                ST_STEP: begin
                    st    <= ST_HALT;
                    cause <= is_ebreak ? CAUSE_EBREAK : CAUSE_HOST;
                end
                ST_HALT: begin
                    if (do_cmd) begin
                        unique case (cmd)
                            CMD_START: begin
                                st    <= ST_RST_PULSE;
                                cause <= CAUSE_NONE;
                            end
                            CMD_ABORT: begin
                                st    <= ST_IDLE;
                                cause <= CAUSE_NONE;
                            end
                            CMD_STEP: begin
                                if (!(cause inside {CAUSE_EBREAK, CAUSE_TIMEOUT})) st <= ST_STEP;
                            end
                            CMD_RESUME: begin
                                if (!(cause inside {CAUSE_EBREAK, CAUSE_TIMEOUT})) begin
                                    st    <= ST_RUN;
                                    cause <= CAUSE_NONE;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    run_cycle_counter u_cycle_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (do_cmd && (cmd == CMD_START)),
        .en    (core_en),
        .count (cycle_cnt)
    );

endmodule
